// File: rtl/arp_server_hls_deadlock_report_ctrl.sv
// Deadlock report sequencer: debounces per-process detect flags, launches the report
// token from one origin, traces the cycle and presents one report. Optional rearm: ARP_DL_REARM_EN.
module arp_server_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM       = 4,
  parameter int PERSIST_CYCLES = 4,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  output logic                dl_detect_bcast,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                report_vld,
  input  logic                report_rdy,
  output logic [PROC_NUM-1:0] report_origin,
  output logic [PROC_NUM-1:0] report_members,
  output logic                report_timeout,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILTER = 3'd1,
    S_LAUNCH = 3'd2,
    S_TRACE  = 3'd3,
    S_CLEAR  = 3'd4,
    S_REPORT = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int PTR_W = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = '1;
  localparam logic [7:0] PERSIST_LAST = 8'(PERSIST_CYCLES);

  state_t                state_q, state_d;
  logic [PROC_NUM-1:0]   sel_q, sel_d, cand;
  logic [7:0]            persist_cnt_q, persist_cnt_d;
  logic [PROC_NUM-1:0]   members_q, members_d;
  logic [TIMEOUT_W-1:0]  timer_q, timer_d;
  logic                  timeout_flag_q, timeout_flag_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  dl_detect_bcast_q, dl_detect_bcast_d;
  logic [PROC_NUM-1:0]   origin_vec_q, origin_vec_d;
  logic                  token_clear_q, token_clear_d;
  logic                  report_vld_q, report_vld_d;
  logic [PROC_NUM-1:0]   report_origin_q, report_origin_d;
  logic [PROC_NUM-1:0]   report_members_q, report_members_d;
  logic                  report_timeout_q, report_timeout_d;
  logic                  busy_q, busy_d;

  // First set bit at or above start, wrapping; start is 0 unless round-robin is enabled.
  function automatic logic [PROC_NUM-1:0] pick(input logic [PROC_NUM-1:0] v,
                                               input logic [PTR_W-1:0] start);
    logic [PROC_NUM-1:0] r;
    logic found;
    int idx;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < PROC_NUM; i++) begin
      idx = (int'(start) + i) % PROC_NUM;
      if (!found && v[idx]) begin
        r[idx] = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef ARP_DL_REARM_EN
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PROC_NUM-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < PROC_NUM; i++) if (oh[i]) r = (i + 1) % PROC_NUM;
    return PTR_W'(r);
  endfunction
`endif

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    persist_cnt_d    = persist_cnt_q;
    members_d        = members_q;
    timer_d          = timer_q;
    timeout_flag_d   = timeout_flag_q;
    rr_ptr_d         = rr_ptr_q;
    report_origin_d  = report_origin_q;
    report_members_d = report_members_q;
    report_timeout_d = report_timeout_q;
    cand             = pick(dl_detect_vec, rr_ptr_q);

    case (state_q)
      S_IDLE: begin
        if (dl_detect_vec != '0) begin
          sel_d         = cand;
          persist_cnt_d = 8'd1;
          state_d       = (PERSIST_CYCLES <= 1) ? S_LAUNCH : S_FILTER;
        end
      end
      S_FILTER: begin
        if ((dl_detect_vec & sel_q) != '0) begin
          persist_cnt_d = persist_cnt_q + 8'd1;
          if (persist_cnt_q + 8'd1 >= PERSIST_LAST) state_d = S_LAUNCH;
        end else begin
          persist_cnt_d = '0;
          sel_d         = '0;
          state_d       = S_IDLE;
        end
      end
      S_LAUNCH: begin
        members_d     = sel_q;
        timer_d       = '0;
        persist_cnt_d = '0;
`ifdef ARP_DL_REARM_EN
        rr_ptr_d      = next_ptr(sel_q);
`endif
        state_d       = S_TRACE;
      end
      S_TRACE: begin
        // Token return beats a timeout landing in the same cycle.
        members_d = members_q | token_vec;
        timer_d   = timer_q + 1'b1;
        if ((token_vec & sel_q) != '0) begin
          timeout_flag_d = 1'b0;
          state_d        = S_CLEAR;
        end else if (timer_q + 1'b1 == TIMER_MAX) begin
          timeout_flag_d = 1'b1;
          state_d        = S_CLEAR;
        end
      end
      S_CLEAR: begin
        report_origin_d  = sel_q;
        report_members_d = members_q;
        report_timeout_d = timeout_flag_q;
        persist_cnt_d    = '0;
        state_d          = S_REPORT;
      end
      S_REPORT: begin
        if (report_vld_q && report_rdy) state_d = S_HALT;
      end
      S_HALT: begin
`ifdef ARP_DL_REARM_EN
        if (dl_detect_vec == '0) begin
          persist_cnt_d = persist_cnt_q + 8'd1;
          if (persist_cnt_q + 8'd1 >= PERSIST_LAST) begin
            persist_cnt_d    = '0;
            sel_d            = '0;
            report_origin_d  = '0;
            report_members_d = '0;
            report_timeout_d = 1'b0;
            state_d          = S_IDLE;
          end
        end else begin
          persist_cnt_d = '0;
        end
`else
        state_d = S_HALT;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with it.
    busy_d            = (state_d != S_IDLE);
    dl_detect_bcast_d = (state_d inside {S_LAUNCH, S_TRACE, S_CLEAR, S_REPORT, S_HALT});
    origin_vec_d      = (state_d == S_LAUNCH) ? sel_d : '0;
    token_clear_d     = (state_d == S_CLEAR);
    report_vld_d      = (state_d == S_REPORT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      sel_q             <= '0;
      persist_cnt_q     <= '0;
      members_q         <= '0;
      timer_q           <= '0;
      timeout_flag_q    <= 1'b0;
      rr_ptr_q          <= '0;
      dl_detect_bcast_q <= 1'b0;
      origin_vec_q      <= '0;
      token_clear_q     <= 1'b0;
      report_vld_q      <= 1'b0;
      report_origin_q   <= '0;
      report_members_q  <= '0;
      report_timeout_q  <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      sel_q             <= sel_d;
      persist_cnt_q     <= persist_cnt_d;
      members_q         <= members_d;
      timer_q           <= timer_d;
      timeout_flag_q    <= timeout_flag_d;
      rr_ptr_q          <= rr_ptr_d;
      dl_detect_bcast_q <= dl_detect_bcast_d;
      origin_vec_q      <= origin_vec_d;
      token_clear_q     <= token_clear_d;
      report_vld_q      <= report_vld_d;
      report_origin_q   <= report_origin_d;
      report_members_q  <= report_members_d;
      report_timeout_q  <= report_timeout_d;
      busy_q            <= busy_d;
    end
  end

  assign dl_detect_bcast = dl_detect_bcast_q;
  assign origin_vec      = origin_vec_q;
  assign token_clear     = token_clear_q;
  assign report_vld      = report_vld_q;
  assign report_origin   = report_origin_q;
  assign report_members  = report_members_q;
  assign report_timeout  = report_timeout_q;
  assign busy            = busy_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_arp_server_hls_deadlock_report_ctrl.sv
// Bench for the deadlock report sequencer: vector table, reset-in-trace sequence and
// randomized cases checked against a behavioural model of detect/trace/report.
module tb_arp_server_hls_deadlock_report_ctrl;
  localparam int PERSIST = 4;
  localparam int TW      = 4;
  localparam int TMAX    = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dl_detect_vec = '0;
  logic [3:0] token_vec = '0;
  logic       report_rdy = 1'b0;
  logic       dl_detect_bcast, token_clear, report_vld, report_timeout, busy;
  logic [3:0] origin_vec, report_origin, report_members;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  always #5 clock = ~clock;

  arp_server_hls_deadlock_report_ctrl #(
    .PROC_NUM(4), .PERSIST_CYCLES(PERSIST), .TIMEOUT_W(TW)
  ) dut (
    .clock(clock), .reset(reset),
    .dl_detect_vec(dl_detect_vec), .token_vec(token_vec),
    .dl_detect_bcast(dl_detect_bcast), .origin_vec(origin_vec),
    .token_clear(token_clear), .report_vld(report_vld), .report_rdy(report_rdy),
    .report_origin(report_origin), .report_members(report_members),
    .report_timeout(report_timeout), .busy(busy), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [3:0]  dl;
    int          hold;
    int          tlen;
    logic [63:0] toks;
    int          bp;
    logic        launch;
    logic [3:0]  org;
    logic [3:0]  mem;
    logic        to;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] all_outs();
    return {dl_detect_bcast, origin_vec, token_clear, report_vld,
            report_origin, report_members, report_timeout, busy};
  endfunction

  // Launch needs PERSIST consecutive samples of a nonzero detect; origin is its lowest bit.
  // Trace cycle k sees token k; it ends on the first token touching the origin, else after TMAX cycles.
  function automatic void ref_model(input logic [3:0] dl, input int hold, input int tlen,
                                    input logic [63:0] toks, output logic launch,
                                    output logic [3:0] org, output logic [3:0] mem,
                                    output logic to, output int exit_k);
    logic [3:0] t;
    logic hit;
    launch = (dl != 4'b0) && (hold >= PERSIST);
    org = 4'b0;
    for (int i = 3; i >= 0; i--) if (dl[i]) org = 4'(1 << i);
    mem = org;
    to = 1'b1;
    exit_k = TMAX;
    hit = 1'b0;
    for (int k = 1; k <= TMAX; k++) begin
      if (!hit) begin
        t = (k <= tlen) ? toks[4*(k-1) +: 4] : 4'b0;
        mem = mem | t;
        if ((t & org) != 4'b0) begin
          hit = 1'b1;
          to = 1'b0;
          exit_k = k;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    dl_detect_vec = '0;
    token_vec = '0;
    report_rdy = 1'b0;
    @(negedge clock);
    chk("reset_outputs", 32'(all_outs()), 32'h0);
    reset = 1'b0;
  endtask

  task automatic run_case(input logic [3:0] dl, input int hold, input int tlen,
                          input logic [63:0] toks, input int bp, input logic exp_launch,
                          input logic [3:0] exp_org, input logic [3:0] exp_mem, input logic exp_to);
    logic m_l, m_t;
    logic [3:0] m_o, m_m;
    int exit_k, k, vld_cycles, origin_pulses, clr_pulses, clr_k, post, transfers;
    int stable_err, halt_err, bcast_seen;
    logic launched, done, xfer_pending;
    logic [8:0] cap, exp_rec;
    ref_model(dl, hold, tlen, toks, m_l, m_o, m_m, m_t, exit_k);
    if (exp_launch) exp_q.push_back({exp_org, exp_mem, exp_to});
    do_reset();
    k = 0; vld_cycles = 0; origin_pulses = 0; clr_pulses = 0; clr_k = -1; post = 0;
    transfers = 0; stable_err = 0; halt_err = 0; bcast_seen = 0;
    launched = 1'b0; done = 1'b0; xfer_pending = 1'b0; cap = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clock);
      if (launched) k++;
      if (xfer_pending) begin
        xfer_pending = 1'b0;
        transfers++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_report actual=%0h expected=none", cap);
        end else begin
          exp_rec = exp_q.pop_front();
          chk("report_fields", 32'(cap), 32'(exp_rec));
        end
        chk("vld_after_xfer", 32'(report_vld), 32'h0);
      end
      if (c == 1) chk("busy_in_filter", 32'(busy), 32'(dl != 4'b0));
      if (dl_detect_bcast) bcast_seen++;
      if (origin_vec != 4'b0) begin
        origin_pulses++;
        if (!launched) begin
          launched = 1'b1;
          k = 0;
          chk("origin_time", 32'(c), 32'(PERSIST));
          chk("origin_vec", 32'(origin_vec), 32'(exp_org));
          chk("bcast_at_launch", 32'(dl_detect_bcast), 32'h1);
        end
      end
      if (token_clear) begin
        clr_pulses++;
        if (clr_k < 0) clr_k = k;
      end
      if (transfers > 0) begin
        post++;
        if (origin_vec != 4'b0 || token_clear || report_vld || !busy || !dl_detect_bcast ||
            {report_origin, report_members, report_timeout} !== cap) halt_err++;
        if (post >= 6) done = 1'b1;
      end
      report_rdy = 1'b0;
      if (report_vld && transfers == 0) begin
        if (vld_cycles == 0) cap = {report_origin, report_members, report_timeout};
        else if ({report_origin, report_members, report_timeout} !== cap) stable_err++;
        vld_cycles++;
        if (vld_cycles > bp) begin
          report_rdy = 1'b1;
          xfer_pending = 1'b1;
        end
      end
      if (!exp_launch && c >= hold + 12) done = 1'b1;
      if (transfers > 0) begin
        dl_detect_vec = 4'($urandom_range(1, 15));
        token_vec = 4'($urandom_range(1, 15));
      end else begin
        dl_detect_vec = (c < hold) ? dl : 4'b0;
        token_vec = (launched && k >= 1 && k <= tlen) ? toks[4*(k-1) +: 4] : 4'b0;
      end
    end
    report_rdy = 1'b0;
    dl_detect_vec = '0;
    token_vec = '0;
    chk("case_done", 32'(done), 32'h1);
    if (exp_launch) begin
      chk("origin_pulses", 32'(origin_pulses), 32'h1);
      chk("clear_pulses", 32'(clr_pulses), 32'h1);
      chk("clear_time", 32'(clr_k), 32'(exit_k + 1));
      chk("vld_cycles", 32'(vld_cycles), 32'(bp + 1));
      chk("report_stable", 32'(stable_err), 32'h0);
      chk("transfers", 32'(transfers), 32'h1);
      chk("halt_hold", 32'(halt_err), 32'h0);
    end else begin
      chk("no_origin", 32'(origin_pulses), 32'h0);
      chk("no_clear", 32'(clr_pulses), 32'h0);
      chk("no_report", 32'(vld_cycles), 32'h0);
      chk("no_bcast", 32'(bcast_seen), 32'h0);
      chk("busy_back_idle", 32'(busy), 32'h0);
    end
  endtask

  task automatic reset_mid_trace();
    int seen;
    logic [3:0] org;
    do_reset();
    seen = -1;
    org = '0;
    for (int c = 0; c < 20 && seen < 0; c++) begin
      @(negedge clock);
      if (origin_vec != 4'b0) seen = c;
      dl_detect_vec = 4'b0100;
    end
    chk("mid_launch_time", 32'(seen), 32'(PERSIST));
    token_vec = 4'b0;
    repeat (3) @(negedge clock);
    chk("mid_trace_busy", 32'({busy, dl_detect_bcast}), 32'h3);
    #2 reset = 1'b1;
    #1 chk("mid_trace_async_reset", 32'(all_outs()), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    dl_detect_vec = 4'b0001;
    seen = -1;
    for (int c = 1; c < 20 && seen < 0; c++) begin
      @(negedge clock);
      if (origin_vec != 4'b0) begin
        seen = c;
        org = origin_vec;
      end
    end
    chk("restart_launch_time", 32'(seen), 32'(PERSIST));
    chk("restart_origin", 32'(org), 32'h1);
    dl_detect_vec = 4'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    logic m_l, m_t;
    logic [3:0] m_o, m_m, dl, org_guess, t;
    logic [63:0] tk;
    int exit_k, hold, tlen, bp;

    vecs[0] = '{4'b0100, 100, 3,  64'h0000_0000_0000_0482, 10, 1'b1, 4'b0100, 4'b1110, 1'b0};
    vecs[1] = '{4'b0001, 3,   0,  64'h0,                   0,  1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[2] = '{4'b1010, 100, 1,  64'h0000_0000_0000_0002, 0,  1'b1, 4'b0010, 4'b0010, 1'b0};
    vecs[3] = '{4'b0100, 100, 16, 64'h1111_1111_1111_1111, 3,  1'b1, 4'b0100, 4'b0101, 1'b1};
    vecs[4] = '{4'b1000, 4,   2,  64'h0000_0000_0000_0081, 1,  1'b1, 4'b1000, 4'b1001, 1'b0};
    vecs[5] = '{4'b0001, 100, 16, 64'h0100_0000_0000_0000, 2,  1'b1, 4'b0001, 4'b0001, 1'b0};
    vecs[6] = '{4'b0001, 100, 16, 64'h1000_0000_0000_0002, 0,  1'b1, 4'b0001, 4'b0011, 1'b1};
    vecs[7] = '{4'b0110, 3,   0,  64'h0,                   0,  1'b0, 4'b0000, 4'b0000, 1'b0};

    for (int i = 0; i < 8; i++)
      run_case(vecs[i].dl, vecs[i].hold, vecs[i].tlen, vecs[i].toks, vecs[i].bp,
               vecs[i].launch, vecs[i].org, vecs[i].mem, vecs[i].to);

    reset_mid_trace();

    for (int n = 0; n < 40; n++) begin
      dl = 4'($urandom_range(1, 15));
      hold = $urandom_range(1, 8);
      tlen = $urandom_range(0, 16);
      bp = $urandom_range(0, 4);
      org_guess = dl & (~dl + 4'd1);
      tk = '0;
      for (int j = 0; j < 16; j++) begin
        t = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) != 0) t = t & ~org_guess;
        tk[4*j +: 4] = t;
      end
      ref_model(dl, hold, tlen, tk, m_l, m_o, m_m, m_t, exit_k);
      run_case(dl, hold, tlen, tk, bp, m_l, m_o, m_m, m_t);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
